// File: rtl/spi_master_tx_mlane.sv
// SPI master transmit datapath: serialises valid/ready words onto 1, 2 or 4 lanes,
// MSB- or LSB-first, for a programmable bit count spanning one or more words.
module spi_master_tx_mlane #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              tx_edge,
  input  logic [1:0]        mode,
  input  logic              lsb_first,
  input  logic [CNT_W-1:0]  counter_in,
  input  logic              counter_in_upd,
  input  logic [DATA_W-1:0] data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [3:0]        sdo,
  output logic              clk_en_o,
  output logic              tx_done,
  output logic              underrun,
  output logic              busy
);

  localparam int unsigned WC_W = $clog2(DATA_W);

  typedef enum logic {IDLE, TRANSMIT} state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic [CNT_W-1:0]    beat_cnt, beat_n;
  logic [WC_W-1:0]     word_cnt, word_n;
  logic [CNT_W-1:0]    tgt_bits, tgt_n;
  logic [1:0]          act_mode, amode_n;
  logic                act_lsb, alsb_n;
  logic [CNT_W-1:0]    act_beats, abeats_n;

  logic [1:0]          cur_sh, act_sh;
  logic [CNT_W-1:0]    rem_mask, beats_in;
  logic [WC_W-1:0]     bpw_m1;
  logic [2:0]          lanes;
  logic                final_beat, word_end, load;

  function automatic logic [1:0] lane_log2(input logic [1:0] m);
    case (m)
      2'b01:   return 2'd1;
      2'b10:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Beat count for the next start: ceil(bits / L) without leaving CNT_W bits
  always_comb begin
    cur_sh   = lane_log2(mode);
    act_sh   = lane_log2(act_mode);
    lanes    = 3'(1) << act_sh;
    rem_mask = (CNT_W'(1) << cur_sh) - CNT_W'(1);
    beats_in = (tgt_bits >> cur_sh) + CNT_W'(|(tgt_bits & rem_mask));
    bpw_m1   = WC_W'((DATA_W >> act_sh) - 1);
    final_beat = (state == TRANSMIT) && tx_edge && (beat_cnt == act_beats - CNT_W'(1));
    word_end   = (state == TRANSMIT) && tx_edge && (word_cnt == bpw_m1) && !final_beat;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      shreg     <= '0;
      beat_cnt  <= '0;
      word_cnt  <= '0;
      tgt_bits  <= CNT_W'(8);
      act_mode  <= 2'b00;
      act_lsb   <= 1'b0;
      act_beats <= '0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      beat_cnt  <= beat_n;
      word_cnt  <= word_n;
      tgt_bits  <= tgt_n;
      act_mode  <= amode_n;
      act_lsb   <= alsb_n;
      act_beats <= abeats_n;
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    beat_n     = beat_cnt;
    word_n     = word_cnt;
    tgt_n      = tgt_bits;
    amode_n    = act_mode;
    alsb_n     = act_lsb;
    abeats_n   = act_beats;
    data_ready = 1'b0;
    clk_en_o   = 1'b0;
    tx_done    = 1'b0;
    underrun   = 1'b0;
    busy       = 1'b0;
    load       = 1'b0;

    if (counter_in_upd) tgt_n = counter_in;

    case (state)
      IDLE: begin
        if (en && data_valid && (beats_in != '0)) begin
          load    = 1'b1;
          state_n = TRANSMIT;
        end
      end
      TRANSMIT: begin
        busy     = 1'b1;
        clk_en_o = 1'b1;
        if (tx_edge) begin
          shreg_n = act_lsb ? (shreg >> lanes) : (shreg << lanes);
          beat_n  = beat_cnt + CNT_W'(1);
          word_n  = (word_cnt == bpw_m1) ? '0 : word_cnt + WC_W'(1);
          if (final_beat) begin
            tx_done = 1'b1;
            beat_n  = '0;
            word_n  = '0;
            if (en && data_valid) begin
              load = 1'b1;
            end else begin
              clk_en_o = 1'b0;
              state_n  = IDLE;
            end
          end else if (word_end) begin
            // Mid-transfer refill ignores en; a missing word aborts the transfer
            if (data_valid) begin
              data_ready = 1'b1;
              shreg_n    = data;
            end else begin
              underrun = 1'b1;
              clk_en_o = 1'b0;
              beat_n   = '0;
              word_n   = '0;
              state_n  = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      data_ready = 1'b1;
      shreg_n    = data;
      amode_n    = mode;
      alsb_n     = lsb_first;
      abeats_n   = beats_in;
    end
  end

  // Lane mapping; unused lanes and IDLE drive 0
  always_comb begin
    sdo = 4'b0000;
    if (state == TRANSMIT) begin
      case (act_sh)
        2'd1:    sdo[1:0] = act_lsb ? shreg[1:0] : shreg[DATA_W-1 -: 2];
        2'd2:    sdo      = act_lsb ? shreg[3:0] : shreg[DATA_W-1 -: 4];
        default: sdo[0]   = act_lsb ? shreg[0]   : shreg[DATA_W-1];
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_tx_mlane.sv
// Self-checking bench for spi_master_tx_mlane: vector table, hand-written corner
// sequences and randomised transfers checked against a bit-position model.
module tb_spi_master_tx_mlane;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic              en, tx_edge, lsb_first, counter_in_upd, data_valid;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  counter_in;
  logic [DATA_W-1:0] data;
  logic              data_ready, clk_en_o, tx_done, underrun, busy;
  logic [3:0]        sdo;

  logic [DATA_W-1:0] words [8];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_master_tx_mlane #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .en(en), .tx_edge(tx_edge), .mode(mode),
    .lsb_first(lsb_first), .counter_in(counter_in), .counter_in_upd(counter_in_upd),
    .data(data), .data_valid(data_valid), .data_ready(data_ready), .sdo(sdo),
    .clk_en_o(clk_en_o), .tx_done(tx_done), .underrun(underrun), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Lane j of beat b, located directly in the original word stream
  function automatic logic [3:0] exp_sdo(input int lanes, input bit l, input int b);
    int bpw, w, k, idx;
    logic [DATA_W-1:0] wd;
    logic [3:0] r;
    bpw = DATA_W / lanes;
    w = b / bpw;
    k = b % bpw;
    wd = words[w % 8];
    r = 4'b0000;
    for (int j = 0; j < lanes; j++) begin
      idx = l ? (k * lanes + j) : (DATA_W - lanes + j - k * lanes);
      r[j] = wd[idx];
    end
    return r;
  endfunction

  task automatic run_xfer(input logic [1:0] m, input logic l, input int bits,
                          input int nvalid, input int gap_pct, input bit do_upd,
                          output int first_sdo, output int last_sdo, output int beats_seen);
    int lanes, beats, bpw, widx, b;
    bit fin, bnd, edge_now, stop;
    lanes = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
    beats = (bits + lanes - 1) / lanes;
    bpw   = DATA_W / lanes;
    if (do_upd) begin
      @(negedge clk);
      counter_in = CNT_W'(bits);
      counter_in_upd = 1'b1;
    end
    @(negedge clk);
    counter_in_upd = 1'b0;
    mode = m; lsb_first = l; en = 1'b1; data_valid = 1'b1; data = words[0]; tx_edge = 1'b0;
    #1 chk("start_ready", 32'(data_ready), 32'd1);
    @(posedge clk);
    widx = 1; b = 0; stop = 0; beats_seen = 0; first_sdo = 0; last_sdo = 0;
    while (!stop) begin
      @(negedge clk);
      en = 1'b0;
      mode = 2'($urandom);
      lsb_first = 1'($urandom);
      edge_now = ($urandom_range(99) >= gap_pct);
      tx_edge = edge_now;
      data_valid = (widx < nvalid);
      data = words[widx % 8];
      fin = (b == beats - 1);
      bnd = ((b % bpw) == bpw - 1) && !fin;
      #1;
      chk("busy", 32'(busy), 32'd1);
      chk("sdo", 32'(sdo), 32'(exp_sdo(lanes, l, b)));
      if (b == 0) first_sdo = int'(sdo);
      last_sdo = int'(sdo);
      chk("clk_en", 32'(clk_en_o), 32'(!(edge_now && (fin || (bnd && widx >= nvalid)))));
      chk("tx_done", 32'(tx_done), 32'(edge_now && fin));
      chk("underrun", 32'(underrun), 32'(edge_now && bnd && widx >= nvalid));
      chk("data_ready", 32'(data_ready), 32'(edge_now && bnd && widx < nvalid));
      if (edge_now) begin
        beats_seen++;
        if (fin || (bnd && widx >= nvalid)) stop = 1;
        else begin
          if (bnd) widx++;
          b++;
        end
      end
      @(posedge clk);
    end
    @(negedge clk);
    tx_edge = 1'b0; data_valid = 1'b0;
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_clk_en", 32'(clk_en_o), 32'd0);
    chk("idle_sdo", 32'(sdo), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  m;
    logic        l;
    int          bits;
    logic [31:0] d;
    int          beats;
    int          first;
    int          last;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int fs, ls, bs, lanes, beats, needed, nv, bits;
    logic [1:0] m;
    logic l;
    logic [7:0] pat;

    tbl[0] = '{2'b00, 1'b0, 32, 32'hA5A5_0F0F, 32, 1, 1};
    tbl[1] = '{2'b10, 1'b1, 16, 32'h0000_1234, 4, 4, 1};
    tbl[2] = '{2'b01, 1'b0, 8,  32'hC000_0000, 4, 3, 0};
    tbl[3] = '{2'b10, 1'b0, 12, 32'h9AB0_0000, 3, 9, 11};
    tbl[4] = '{2'b11, 1'b1, 5,  32'h0000_0012, 5, 0, 1};
    tbl[5] = '{2'b01, 1'b1, 3,  32'h0000_0006, 2, 2, 1};

    rstn = 1'b0; en = 1'b0; tx_edge = 1'b0; lsb_first = 1'b0; counter_in_upd = 1'b0;
    data_valid = 1'b0; mode = 2'b00; counter_in = '0; data = '0;
    for (int i = 0; i < 8; i++) words[i] = '0;
    #2;
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clk_en", 32'(clk_en_o), 32'd0);
    chk("rst_flags", {29'd0, tx_done, underrun, data_ready}, 32'd0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;

    // Vector table: single-word transfers with hand-derived beat count and end lanes
    for (int i = 0; i < 6; i++) begin
      words[0] = tbl[i].d;
      run_xfer(tbl[i].m, tbl[i].l, tbl[i].bits, 1, 0, 1'b1, fs, ls, bs);
      chk("tbl_beats", 32'(bs), 32'(tbl[i].beats));
      chk("tbl_first", 32'(fs), 32'(tbl[i].first));
      chk("tbl_last", 32'(ls), 32'(tbl[i].last));
    end

    // Dual lane, 80 bits over three words
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    run_xfer(2'b01, 1'b0, 80, 3, 0, 1'b1, fs, ls, bs);
    chk("multi_beats", 32'(bs), 32'd40);

    // Underrun after first word
    run_xfer(2'b00, 1'b0, 64, 1, 0, 1'b1, fs, ls, bs);
    chk("underrun_beats", 32'(bs), 32'd32);

    // Back-to-back with a mode change mid-transfer
    pat = 8'h5A;
    @(negedge clk);
    counter_in = CNT_W'(8); counter_in_upd = 1'b1;
    @(negedge clk);
    counter_in_upd = 1'b0;
    mode = 2'b00; lsb_first = 1'b0; en = 1'b1; data_valid = 1'b1; data = 32'h5A00_0000;
    #1 chk("b2b_start", 32'(data_ready), 32'd1);
    @(posedge clk);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      en = 1'b0; data_valid = 1'b0; tx_edge = 1'b1;
      if (b == 3) mode = 2'b10;
      if (b == 7) begin en = 1'b1; data_valid = 1'b1; data = 32'hC300_0000; end
      #1;
      chk("b2b_sdo1", 32'(sdo), 32'(pat[7-b]));
      chk("b2b_done1", 32'(tx_done), 32'(b == 7));
      chk("b2b_ready1", 32'(data_ready), 32'(b == 7));
      chk("b2b_clk_en1", 32'(clk_en_o), 32'd1);
      @(posedge clk);
    end
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      en = 1'b0; data_valid = 1'b0; tx_edge = 1'b1;
      #1;
      chk("b2b_sdo2", 32'(sdo), (b == 0) ? 32'hC : 32'h3);
      chk("b2b_done2", 32'(tx_done), 32'(b == 1));
      @(posedge clk);
    end
    @(negedge clk);
    tx_edge = 1'b0;
    #1 chk("b2b_idle", 32'(busy), 32'd0);

    // Zero-length target never starts
    @(negedge clk);
    counter_in = '0; counter_in_upd = 1'b1;
    @(negedge clk);
    counter_in_upd = 1'b0; en = 1'b1; data_valid = 1'b1;
    #1 chk("zero_ready", 32'(data_ready), 32'd0);
    @(negedge clk);
    #1 chk("zero_busy", 32'(busy), 32'd0);
    en = 1'b0; data_valid = 1'b0;

    // Reset mid-transfer restores the default 8-bit target
    @(negedge clk);
    counter_in = CNT_W'(40); counter_in_upd = 1'b1;
    @(negedge clk);
    counter_in_upd = 1'b0; mode = 2'b00; lsb_first = 1'b0; en = 1'b1; data_valid = 1'b1;
    data = 32'hFFFF_FFFF;
    @(negedge clk);
    en = 1'b0; data_valid = 1'b0;
    for (int b = 0; b < 5; b++) begin
      tx_edge = 1'b1;
      @(negedge clk);
    end
    #1 chk("pre_rst_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_sdo", 32'(sdo), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_clk_en", 32'(clk_en_o), 32'd0);
    chk("mid_rst_flags", {29'd0, tx_done, underrun, data_ready}, 32'd0);
    tx_edge = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    words[0] = 32'h8100_0000;
    run_xfer(2'b00, 1'b0, 8, 1, 0, 1'b0, fs, ls, bs);
    chk("rst_target_beats", 32'(bs), 32'd8);

    // Randomised transfers with strobe gaps and occasional starvation
    for (int it = 0; it < 25; it++) begin
      m = 2'($urandom_range(3));
      l = 1'($urandom);
      bits = $urandom_range(1, 150);
      lanes = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
      beats = (bits + lanes - 1) / lanes;
      needed = (beats + (DATA_W / lanes) - 1) / (DATA_W / lanes);
      nv = ($urandom_range(3) == 0) ? $urandom_range(1, needed) : needed;
      for (int i = 0; i < 8; i++) words[i] = $urandom;
      run_xfer(m, l, bits, nv, 25, 1'b1, fs, ls, bs);
      chk("rand_beats", 32'(bs), (nv >= needed) ? 32'(beats) : 32'(nv * (DATA_W / lanes)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
